// File: rtl/serial_adder_ctrl_if.sv
// Requester handshake and full-adder cell signals of serial_adder_ctrl.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             ovf;

    modport slave (
        input  start, a_in, b_in, cin_in, fa_sum, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum_out, cout_out, ovf
    );

    modport master (
        output start, a_in, b_in, cin_in, fa_sum, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum_out, cout_out, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer around one external full adder, LSB first.
// SERIAL_ADDER_OVF_EN adds signed-overflow detection on the ovf output.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_next;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run;
    logic             accept;
    logic             last;

    assign run    = (state_q == S_RUN);
    assign accept = bus.start && !run;
    assign last   = run && (cnt_q == CW'(WIDTH - 1));

    if (WIDTH > 1) begin : g_wide
        assign sum_next = {bus.fa_sum, sum_sh_q[WIDTH-1:1]};
    end else begin : g_one
        assign sum_next = bus.fa_sum;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        if (accept) begin
            state_d  = S_RUN;
            a_sh_d   = bus.a_in;
            b_sh_d   = bus.b_in;
            sum_sh_d = '0;
            carry_d  = bus.cin_in;
            cnt_d    = '0;
        end else if (run) begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = sum_next;
            carry_d  = bus.fa_cout;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                state_d = S_DONE;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy   = run;
    assign bus.done   = (state_q == S_DONE);
    assign bus.fa_a   = run & a_sh_q[0];
    assign bus.fa_b   = run & b_sh_q[0];
    assign bus.fa_cin = run & carry_q;

    // Shift and carry regs hold the result after RUN; masking them during
    // RUN gives the cleared-on-accept behaviour without a second register.
    assign bus.sum_out  = run ? '0 : sum_sh_q;
    assign bus.cout_out = ~run & carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic cmsb_q, cmsb_d;

    always_comb begin
        cmsb_d = cmsb_q;
        if (accept) begin
            cmsb_d = 1'b0;
        end else if (last) begin
            cmsb_d = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmsb_q <= 1'b0;
        end else begin
            cmsb_q <= cmsb_d;
        end
    end

    assign bus.ovf = ~run & (cmsb_q ^ carry_q);
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with a
// behavioural full adder and a result scoreboard.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst_n;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.fa_sum  = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
    assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_ovf(input logic [7:0] a, input logic [7:0] b,
                                     input logic cin);
`ifdef SERIAL_ADDER_OVF_EN
        logic [7:0] s;
        s = a + b + {7'b0, cin};
        return (a[7] == b[7]) && (s[7] != a[7]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [7:0] s, input logic co);
        exp_t e;
        e.sum  = s;
        e.cout = co;
        e.ovf  = exp_ovf(a, b, cin);
        bus.start  = 1'b1;
        bus.a_in   = a;
        bus.b_in   = b;
        bus.cin_in = cin;
        sb.push_back(e);
        cyc();
        bus.start = 1'b0;
        chk("busy_on_accept", {31'b0, bus.busy}, 32'd1);
        chk("sum_cleared", {24'b0, bus.sum_out}, 32'd0);
        chk("cout_cleared", {31'b0, bus.cout_out}, 32'd0);
        chk("fa_a_bit0", {31'b0, bus.fa_a}, {31'b0, a[0]});
        chk("fa_b_bit0", {31'b0, bus.fa_b}, {31'b0, b[0]});
        chk("fa_cin_init", {31'b0, bus.fa_cin}, {31'b0, cin});
    endtask

    task automatic wait_done(input int lat, input string nm);
        int n;
        int bc;
        n  = 0;
        bc = 0;
        while (!bus.done && n <= lat + 4) begin
            if (bus.busy) bc++;
            cyc();
            n++;
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_busy_cycles"}, bc, lat);
        chk({nm, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done sum=%0h t=%0t", bus.sum_out, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_sum", {24'b0, bus.sum_out}, {24'b0, mon_e.sum});
                chk("sb_cout", {31'b0, bus.cout_out}, {31'b0, mon_e.cout});
                chk("sb_ovf", {31'b0, bus.ovf}, {31'b0, mon_e.ovf});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        bus.cin_in = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_sum", {24'b0, bus.sum_out}, 32'd0);
        chk("rst_cout", {31'b0, bus.cout_out}, 32'd0);
        chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        chk("rst_fa", {29'b0, bus.fa_a, bus.fa_b, bus.fa_cin}, 32'd0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 7; i++) begin
            do_start(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
            wait_done(8, "vec");
            cyc();
            chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
            chk("sum_held", {24'b0, bus.sum_out}, {24'b0, vecs[i].sum});
            chk("cout_held", {31'b0, bus.cout_out}, {31'b0, vecs[i].cout});
            chk("fa_idle", {29'b0, bus.fa_a, bus.fa_b, bus.fa_cin}, 32'd0);
        end

        // start raised while busy must not disturb the running add
        do_start(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        bus.start = 1'b1;
        bus.a_in  = 8'hAA;
        bus.b_in  = 8'h55;
        cyc();
        cyc();
        bus.start = 1'b0;
        wait_done(6, "ignored");
        cyc();

        do_start(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        wait_done(8, "b2b_first");
        do_start(8'h10, 8'h20, 1'b1, 8'h31, 1'b0);
        wait_done(8, "b2b_second");
        cyc();
        chk("b2b_sum_held", {24'b0, bus.sum_out}, 32'h31);

        do_start(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_sum", {24'b0, bus.sum_out}, 32'd0);
        chk("abort_cout", {31'b0, bus.cout_out}, 32'd0);
        sb.delete();
        cyc();
        rst_n = 1'b1;
        dn = 0;
        repeat (12) begin
            cyc();
            if (bus.done) dn++;
        end
        chk("abort_no_done", dn, 0);
        do_start(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        wait_done(8, "after_abort");
        cyc();
        cyc();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
